// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Purpose:
//   Adapts the single-cycle datapath's zero-latency load/store interface to a
//   req/ack handshake towards a variable-latency data memory. While an access
//   is outstanding the bridge raises stall so the datapath holds its PC and
//   suppresses register writeback. The instruction retires in the DONE cycle,
//   with rdata already valid. Misaligned word accesses are rejected without
//   touching the bus.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   memread      in   load request from the control unit
//   memwrite     in   store request from the control unit (wins over memread)
//   addr         in   byte address from the ALU (sampled only in IDLE)
//   wdata        in   store data (sampled only in IDLE)
//   rdata        out  load data to the result mux; holds between loads and is
//                     cleared by a rejected misaligned access
//   stall        out  hold PC / suppress regwrite (combinational)
//   misalign_err out  one-cycle pulse after a rejected misaligned access
//   bus_req      out  registered memory request
//   bus_we       out  1 = write, 0 = read; valid while bus_req is high
//   bus_addr     out  registered word-aligned address
//   bus_wdata    out  registered write data
//   bus_ack      in   memory accepts/completes the current request
//   bus_rdata    in   read data, valid in the bus_ack cycle
//   timeout_err  out  one-cycle pulse when a request is aborted by the watchdog
//
// Build option:
//   DMEM_BRIDGE_TIMEOUT_EN - when defined, a watchdog aborts a request that is
//   not acknowledged within TIMEOUT REQ cycles. The aborted read returns
//   0xDEADBEEF. When undefined, REQ waits indefinitely for bus_ack and
//   timeout_err is constant 0.
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          misalign_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_bus_req;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_misalign_err;

  logic          w_access;
  logic          w_misaligned;
  logic          w_issue;
  logic          w_reject;
  logic          w_ack;
  logic          w_abort;

  assign w_access     = memread | memwrite;
  assign w_misaligned = w_access & (addr[1:0] != 2'b00);
  // Inputs only matter in IDLE; during REQ/DONE the datapath is frozen or
  // retiring, so nothing it presents may start or reject an access.
  assign w_issue      = (r_state == S_IDLE) & w_access & ~w_misaligned;
  assign w_reject     = (r_state == S_IDLE) & w_misaligned;
  // bus_ack outside REQ is ignored.
  assign w_ack        = (r_state == S_REQ) & bus_ack;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;

  // Counter holds the number of unacknowledged REQ cycles already elapsed, so
  // the abort fires in the REQ cycle that would bring it to TIMEOUT. An ack in
  // that same cycle takes precedence.
  assign w_abort = (r_state == S_REQ) & ~bus_ack & (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_abort;
      if (w_issue) begin
        r_tcnt <= '0;
      end else if ((r_state == S_REQ) && !bus_ack) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  // Constant 0 for any legal (non-negative) TIMEOUT; no watchdog is built.
  assign timeout_err = (TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue)           w_next = S_REQ;
      S_REQ:   if (w_ack || w_abort)  w_next = S_DONE;
      S_DONE:                         w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  // Bus request and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req      <= 1'b0;
      r_bus_we       <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_wdata    <= '0;
      r_rdata        <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_reject;

      // Bus fields are loaded only at issue, so they stay stable for the whole
      // REQ phase regardless of what the datapath drives meanwhile.
      if (w_issue) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= memwrite;
        r_bus_addr  <= {addr[AW-1:2], 2'b00};
        r_bus_wdata <= wdata;
      end else if (w_ack || w_abort) begin
        r_bus_req   <= 1'b0;
      end

      if (w_ack && !r_bus_we) begin
        r_rdata <= bus_rdata;
      end else if (w_abort && !r_bus_we) begin
        r_rdata <= DW'(32'hDEADBEEF);
      end else if (w_reject) begin
        // A rejected access returns 0 rather than a stale load value.
        r_rdata <= '0;
      end
    end
  end

  // Stall covers the issuing IDLE cycle and all of REQ; DONE is the retire
  // cycle. Gated by reset so the datapath is never held while in reset.
  assign stall = reset & (w_issue | (r_state == S_REQ));

  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign rdata        = r_rdata;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Directed testbench for dmem_bridge. Inputs are driven just after the falling
// edge and outputs are sampled 1 time unit later, well away from the rising
// edge. Define DMEM_BRIDGE_TIMEOUT_EN for both files to include the watchdog
// scenarios.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          memread;
  logic          memwrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          stall;
  logic          misalign_err;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_bridge #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .timeout_err  (timeout_err)
  );

  task automatic test_reset();
    reset     = 1'b0;
    memread   = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h10;
    wdata     = 32'h0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we, stall, misalign_err, timeout_err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/stall/mis/tmo got %b want 00000",
               {bus_req, bus_we, stall, misalign_err, timeout_err});
    end
    checks++;
    if ({bus_addr, bus_wdata, rdata} !== {32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all 0", bus_addr, bus_wdata, rdata);
    end
    @(negedge clk);
    memread = 1'b0;
    bus_ack = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; addr = 32'h10;
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin
      errors++;
      $display("FAIL read_idle: stall/req got %b want 10", {stall, bus_req});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_req, bus_we, stall, bus_addr} !== {3'b101, 32'h10}) begin
      errors++;
      $display("FAIL read_req: req/we/stall got %b addr=%h want 101 addr=00000010",
               {bus_req, bus_we, stall}, bus_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_req, stall, rdata} !== {2'b00, 32'h12345678}) begin
      errors++;
      $display("FAIL read_done: req/stall got %b rdata=%h want 00 rdata=12345678",
               {bus_req, stall}, rdata);
    end
  endtask

  task automatic test_write_wait();
    int stall_cnt;
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b1; addr = 32'h24; wdata = 32'hCAFEF00D;
    bus_ack = 1'b0; bus_rdata = 32'h11111111;
    #1;
    stall_cnt = int'(stall);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      // Disturb the sampled inputs, including a misaligned address.
      addr    = 32'h99 + i;
      wdata   = ~wdata;
      bus_ack = (i == 5);
      #1;
      stall_cnt += int'(stall);
      checks++;
      if ({bus_req, bus_we, misalign_err, bus_addr, bus_wdata} !==
          {3'b110, 32'h24, 32'hCAFEF00D}) begin
        errors++;
        $display("FAIL write_req_stable[%0d]: req/we/mis=%b addr=%h wdata=%h want 110 00000024 cafef00d",
                 i, {bus_req, bus_we, misalign_err}, bus_addr, bus_wdata);
      end
    end
    @(negedge clk);
    addr = 32'h24; wdata = 32'hCAFEF00D; bus_ack = 1'b0;
    #1;
    stall_cnt += int'(stall);
    checks++;
    if (stall_cnt !== 6) begin
      errors++;
      $display("FAIL write_stall_cycles: got %0d want 6", stall_cnt);
    end
    checks++;
    if ({bus_req, misalign_err, rdata} !== {2'b00, 32'h12345678}) begin
      errors++;
      $display("FAIL write_done: req/mis=%b rdata=%h want 00 rdata=12345678",
               {bus_req, misalign_err}, rdata);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    memwrite = 1'b0; memread = 1'b1; addr = 32'h13; bus_ack = 1'b0;
    #1;
    checks++;
    if ({stall, bus_req} !== 2'b00) begin
      errors++;
      $display("FAIL misalign_rd_idle: stall/req got %b want 00", {stall, bus_req});
    end
    @(negedge clk);
    memread = 1'b0; addr = 32'h0;
    #1;
    checks++;
    if ({misalign_err, stall, bus_req, rdata} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL misalign_rd_pulse: mis/stall/req=%b rdata=%h want 100 rdata=00000000",
               {misalign_err, stall, bus_req}, rdata);
    end
    // Misaligned store (halfword offset) is rejected the same way.
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h22; wdata = 32'h77777777;
    #1;
    checks++;
    if ({misalign_err, stall, bus_req} !== 3'b000) begin
      errors++;
      $display("FAIL misalign_pulse_width: mis/stall/req got %b want 000",
               {misalign_err, stall, bus_req});
    end
    @(negedge clk);
    memwrite = 1'b0; addr = 32'h0;
    #1;
    checks++;
    if ({misalign_err, bus_req} !== 2'b10) begin
      errors++;
      $display("FAIL misalign_wr_pulse: mis/req got %b want 10", {misalign_err, bus_req});
    end
    @(negedge clk); #1;
    checks++;
    if ({misalign_err, bus_req} !== 2'b00) begin
      errors++;
      $display("FAIL misalign_wr_clear: mis/req got %b want 00", {misalign_err, bus_req});
    end
  endtask

  task automatic test_rw_priority();
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b1; addr = 32'h40; wdata = 32'h000055AA;
    bus_ack = 1'b0; bus_rdata = 32'hFFFF0000;
    #1;
    @(negedge clk);
    bus_ack = 1'b1;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== {2'b11, 32'h40, 32'h000055AA}) begin
      errors++;
      $display("FAIL rw_prio_req: req/we=%b addr=%h wdata=%h want 11 00000040 000055aa",
               {bus_req, bus_we}, bus_addr, bus_wdata);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, rdata} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL rw_prio_done: req/stall=%b rdata=%h want 00 rdata=00000000",
               {bus_req, stall}, rdata);
    end
    // Stray ack while idle.
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b1;
    #1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, rdata} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL stray_ack: req/stall=%b rdata=%h want 00 rdata=00000000",
               {bus_req, stall}, rdata);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    memread = 1'b1; addr = 32'h80; bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if ({bus_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_req2: req/stall got %b want 11", {bus_req, stall});
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_drop: req/stall got %b want 00", {bus_req, stall});
    end
    @(negedge clk);
    reset = 1'b1; addr = 32'h84; bus_ack = 1'b1; bus_rdata = 32'hA5A50001;
    #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin
      errors++;
      $display("FAIL rst_after_idle: stall/req got %b want 10", {stall, bus_req});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_req, bus_we, bus_addr} !== {2'b10, 32'h84}) begin
      errors++;
      $display("FAIL rst_after_req: req/we=%b addr=%h want 10 00000084", {bus_req, bus_we}, bus_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_req, stall, rdata} !== {2'b00, 32'hA5A50001}) begin
      errors++;
      $display("FAIL rst_after_done: req/stall=%b rdata=%h want 00 rdata=a5a50001",
               {bus_req, stall}, rdata);
    end
    @(negedge clk);
    memread = 1'b0; bus_ack = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_quiet: timeout_err got %b want 0", timeout_err);
    end
  endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; addr = 32'h100; bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus_req, stall, timeout_err} !== 3'b110) begin
        errors++;
        $display("FAIL tmo_req[%0d]: req/stall/tmo got %b want 110", i, {bus_req, stall, timeout_err});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_req, stall, timeout_err, rdata} !== {3'b001, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL tmo_abort: req/stall/tmo=%b rdata=%h want 001 rdata=deadbeef",
               {bus_req, stall, timeout_err}, rdata);
    end
    @(negedge clk);
    memread = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: timeout_err got %b want 0", timeout_err);
    end
    // Ack in the final allowed cycle wins over the watchdog.
    @(negedge clk);
    memread = 1'b1; addr = 32'h104;
    #1;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      bus_ack = (i == TMO); bus_rdata = 32'h0BADF00D;
      #1;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if ({bus_req, timeout_err, rdata} !== {2'b00, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL tmo_ack_wins: req/tmo=%b rdata=%h want 00 rdata=0badf00d",
               {bus_req, timeout_err}, rdata);
    end
    @(negedge clk);
    memread = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_misaligned();
    test_rw_priority();
    test_reset_mid_req();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
